execute_memory_buffer: RTL and testbench
========================================

Name: execute_memory_buffer

Overview:
- EX/MEM pipeline stage directly downstream of the ALU.
- Registers the ALU result, store data and write-back/memory control for the memory stage.
- Owns the architectural condition-code register (CCR) that is fed back to the ALU.
- Resolves taken conditional jumps by flushing upstream, and saves/restores CCR around interrupts.

Parameters:
DATA_W, 16, datapath width
OP_W, 5, ALU opcode width
REG_W, 3, register-index width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
stall  in  1  hold all stage registers and CCR
flush  in  1  external squash of the incoming instruction
in_valid  in  1  incoming instruction is real (not a bubble)
alu_op  in  OP_W  decoded ALU opcode (20=JZ, 21=JN, 22=JC, 26=RTI)
alu_out  in  DATA_W  ALU result
alu_flags  in  3  flags computed by the ALU: [0]=Z, [1]=N, [2]=C
flags_we  in  1  instruction updates CCR
jump_taken  in  1  ALU conditional-jump result
store_data  in  DATA_W  value to be written to memory
rdst  in  REG_W  destination register
reg_write, mem_read, mem_write  in  1 each  control bits
interrupt  in  1  level request; held by the source until int_ack
ccr  out  3  current CCR, fed back to the ALU
flush_upstream  out  1  combinational; squash IF/ID on a taken jump
int_ack  out  1  registered; high for exactly 1 cycle per accepted interrupt
m_valid, m_alu_out, m_store_data, m_rdst, m_reg_write, m_mem_read, m_mem_write  out  registered stage outputs

Behaviour:
- Accept condition: accept = in_valid & ~flush & ~stall & (state==IDLE).
- Reset: all m_* outputs = 0, ccr = 3'b000, saved_ccr = 0, state = IDLE, int_ack = 0.
  - Reset wins over every other input, including mid-interrupt (the SAVE state is abandoned).
- Latency: 1 cycle from input to m_* outputs.
- stall = 1:
  - All registers hold, including the FSM, ccr and saved_ccr.
  - flush_upstream is forced to 0.
- Bubble: when not stalled and accept = 0, the stage loads a bubble.
  - Bubble = m_valid = 0, all control bits 0, data fields 0.
  - flush takes priority over in_valid.
- Pipeline load: when accept = 1, every field is registered as-is and m_valid = 1.
- CCR next-value priority (evaluated only when not stalled):
  1. accept & alu_op == 26 (RTI): ccr <= saved_ccr.
  2. accept & flags_we: ccr <= alu_flags.
  3. accept & jump_taken & alu_op in {20, 21, 22}: clear the tested bit (bit 0, 1 or 2 respectively); other bits keep their value.
  4. Otherwise ccr holds.
- flush_upstream:
  - Equals accept & jump_taken & (alu_op in {20, 21, 22}), in the same cycle.
  - The jump itself still passes to MEM with its control bits as given.
- Interrupt FSM, states IDLE and SAVE:
  - IDLE -> SAVE when interrupt & ~stall. On that edge:
    - saved_ccr <= ccr_next, i.e. including any update from the instruction accepted in the same cycle.
    - That instruction completes normally.
  - SAVE:
    - Stage loads a bubble.
    - Incoming instructions are not accepted; upstream must hold or refetch them.
    - int_ack = 1.
    - ccr holds.
  - SAVE -> IDLE unconditionally after 1 non-stalled cycle. Stall in SAVE extends SAVE and keeps int_ack high.
  - interrupt still high in the cycle after SAVE is treated as a new request. The source must drop interrupt on int_ack.
- Simultaneous RTI + interrupt in IDLE: RTI restores ccr, and saved_ccr captures that restored value.
- Only one saved level exists; no nesting.

Test Plan:
- Reset then an ADD with flags_we = 1, alu_flags = 3'b101, alu_out = 16'h1234, rdst = 3:
  - one cycle later m_valid = 1, m_alu_out = 16'h1234, m_rdst = 3;
  - ccr = 3'b101.
- ccr = 3'b001, JZ (op 20) with jump_taken = 1:
  - flush_upstream = 1 in the same cycle;
  - ccr = 3'b000 next cycle.
- JN (op 21) with jump_taken = 0: flush_upstream = 0 and ccr unchanged.
- stall held 3 cycles during a valid SUB with flags_we = 1: m_* outputs and ccr frozen throughout; they update on the first non-stalled edge.
- ccr = 3'b110 and interrupt asserted while an AND (flags_we = 1, alu_flags = 3'b001) is accepted:
  - saved_ccr = 3'b001;
  - int_ack pulses for 1 cycle with m_valid = 0 in SAVE;
  - a later SETC sets ccr = 3'b100;
  - a subsequent RTI (op 26) restores ccr to 3'b001.
- rst asserted while in SAVE:
  - next cycle state = IDLE, int_ack = 0, ccr = 0;
  - all m_* outputs = 0.

Source files
------------

// File: rtl/execute_memory_buffer.sv
// execute_memory_buffer
// EX/MEM pipeline register sitting directly after the ALU. Besides carrying
// the ALU result, store data and write-back/memory control into the memory
// stage, it owns the architectural condition-code register (ccr), resolves
// taken conditional jumps by squashing IF/ID, and saves/restores ccr around
// a single-level interrupt using a two-state FSM (IDLE/SAVE).
//
// Handshake: there is no ready/valid backpressure on this stage. in_valid
// marks a real instruction; it is taken only when accept is high
// (in_valid & ~flush & ~stall & IDLE). When accept is low and the stage is
// not stalled, a bubble (m_valid = 0, all fields 0) is loaded instead, so
// upstream must hold or refetch anything that was not accepted.
//
// dbg_state and dbg_saved_ccr expose the FSM state and the saved ccr level
// so that checkers can observe them directly.

module execute_memory_buffer #(
   parameter int DATA_W = 16,
   parameter int OP_W   = 5,
   parameter int REG_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [2:0]        alu_flags,
   input  logic              flags_we,
   input  logic              jump_taken,
   input  logic [DATA_W-1:0] store_data,
   input  logic [REG_W-1:0]  rdst,
   input  logic              reg_write,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              interrupt,
   output logic [2:0]        ccr,
   output logic              flush_upstream,
   output logic              int_ack,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_alu_out,
   output logic [DATA_W-1:0] m_store_data,
   output logic [REG_W-1:0]  m_rdst,
   output logic              m_reg_write,
   output logic              m_mem_read,
   output logic              m_mem_write,
   output logic              dbg_state,
   output logic [2:0]        dbg_saved_ccr
);

   // Opcodes this stage has to recognise.
   localparam logic [OP_W-1:0] OP_JZ  = OP_W'(20);
   localparam logic [OP_W-1:0] OP_JN  = OP_W'(21);
   localparam logic [OP_W-1:0] OP_JC  = OP_W'(22);
   localparam logic [OP_W-1:0] OP_RTI = OP_W'(26);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SAVE = 1'b1
   } state_t;

   state_t            state_q;
   logic [2:0]        ccr_q, ccr_d;
   logic [2:0]        saved_ccr_q;
   logic              int_ack_q;

   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_alu_out_q, m_alu_out_d;
   logic [DATA_W-1:0] m_store_data_q, m_store_data_d;
   logic [REG_W-1:0]  m_rdst_q, m_rdst_d;
   logic              m_reg_write_q, m_reg_write_d;
   logic              m_mem_read_q, m_mem_read_d;
   logic              m_mem_write_q, m_mem_write_d;

   logic              accept;
   logic              is_jcc;
   logic              is_rti;
   logic              jump_resolved;
   logic [2:0]        jcc_clear_mask;

   // An instruction enters only when real, not squashed, not stalled and no
   // interrupt save is in progress.
   assign accept        = in_valid & ~flush & ~stall & (state_q == ST_IDLE);
   assign is_jcc        = (alu_op == OP_JZ) | (alu_op == OP_JN) | (alu_op == OP_JC);
   assign is_rti        = (alu_op == OP_RTI);
   assign jump_resolved = accept & jump_taken & is_jcc;

   // A taken jump squashes IF/ID in the same cycle; accept already folds in
   // stall, so a stalled jump never flushes.
   assign flush_upstream = jump_resolved;

   // Select the ccr bit tested by the conditional jump (Z, N or C).
   always_comb begin
      jcc_clear_mask = 3'b000;
      case (alu_op)
         OP_JZ:   jcc_clear_mask = 3'b001;
         OP_JN:   jcc_clear_mask = 3'b010;
         OP_JC:   jcc_clear_mask = 3'b100;
         default: jcc_clear_mask = 3'b000;
      endcase
   end

   // ccr next value: RTI restore beats a flag write, which beats the
   // jump-consumes-flag clear; anything else leaves ccr alone.
   always_comb begin
      ccr_d = ccr_q;
      if (accept) begin
         if (is_rti) begin
            ccr_d = saved_ccr_q;
         end else if (flags_we) begin
            ccr_d = alu_flags;
         end else if (jump_taken && is_jcc) begin
            ccr_d = ccr_q & ~jcc_clear_mask;
         end
      end
   end

   // Stage payload next value: the instruction as-is when accepted, else a
   // fully zeroed bubble.
   always_comb begin
      m_valid_d      = 1'b0;
      m_alu_out_d    = '0;
      m_store_data_d = '0;
      m_rdst_d       = '0;
      m_reg_write_d  = 1'b0;
      m_mem_read_d   = 1'b0;
      m_mem_write_d  = 1'b0;
      if (accept) begin
         m_valid_d      = 1'b1;
         m_alu_out_d    = alu_out;
         m_store_data_d = store_data;
         m_rdst_d       = rdst;
         m_reg_write_d  = reg_write;
         m_mem_read_d   = mem_read;
         m_mem_write_d  = mem_write;
      end
   end

   // Stage registers: reset clears, stall holds, otherwise load payload/bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_q      <= 1'b0;
         m_alu_out_q    <= '0;
         m_store_data_q <= '0;
         m_rdst_q       <= '0;
         m_reg_write_q  <= 1'b0;
         m_mem_read_q   <= 1'b0;
         m_mem_write_q  <= 1'b0;
      end else if (!stall) begin
         m_valid_q      <= m_valid_d;
         m_alu_out_q    <= m_alu_out_d;
         m_store_data_q <= m_store_data_d;
         m_rdst_q       <= m_rdst_d;
         m_reg_write_q  <= m_reg_write_d;
         m_mem_read_q   <= m_mem_read_d;
         m_mem_write_q  <= m_mem_write_d;
      end
   end

   // Interrupt FSM with ccr, saved_ccr and int_ack as registered outputs.
   // Entering SAVE snapshots ccr_d so an instruction accepted on the same
   // edge (including an RTI restore) is reflected in the saved level.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ccr_q       <= 3'b000;
         saved_ccr_q <= 3'b000;
         int_ack_q   <= 1'b0;
      end else if (!stall) begin
         ccr_q <= ccr_d;
         case (state_q)
            ST_IDLE: begin
               if (interrupt) begin
                  state_q     <= ST_SAVE;
                  saved_ccr_q <= ccr_d;
                  int_ack_q   <= 1'b1;
               end else begin
                  int_ack_q   <= 1'b0;
               end
            end
            ST_SAVE: begin
               state_q   <= ST_IDLE;
               int_ack_q <= 1'b0;
            end
            default: begin
               state_q   <= ST_IDLE;
               int_ack_q <= 1'b0;
            end
         endcase
      end
   end

   assign ccr           = ccr_q;
   assign int_ack       = int_ack_q;
   assign m_valid       = m_valid_q;
   assign m_alu_out     = m_alu_out_q;
   assign m_store_data  = m_store_data_q;
   assign m_rdst        = m_rdst_q;
   assign m_reg_write   = m_reg_write_q;
   assign m_mem_read    = m_mem_read_q;
   assign m_mem_write   = m_mem_write_q;
   assign dbg_state     = state_q;
   assign dbg_saved_ccr = saved_ccr_q;

endmodule

// File: tb/tb_execute_memory_buffer.sv
// Directed and randomized bench for execute_memory_buffer. A small
// behavioural model predicts stage payload, ccr, saved ccr, FSM state and
// int_ack; predicted payloads are queued when stimulus is driven and popped
// after the edge on which the DUT registers them.

module tb_execute_memory_buffer;
   localparam int DATA_W = 16;
   localparam int OP_W   = 5;
   localparam int REG_W  = 3;
   localparam int W      = 1 + DATA_W + DATA_W + REG_W + 3;

   // clock/reset block
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, stall, flush, in_valid;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_out;
   logic [2:0]        alu_flags;
   logic              flags_we, jump_taken;
   logic [DATA_W-1:0] store_data;
   logic [REG_W-1:0]  rdst;
   logic              reg_write, mem_read, mem_write, interrupt;
   logic [2:0]        ccr;
   logic              flush_upstream, int_ack;
   logic              m_valid;
   logic [DATA_W-1:0] m_alu_out, m_store_data;
   logic [REG_W-1:0]  m_rdst;
   logic              m_reg_write, m_mem_read, m_mem_write;
   logic              dbg_state;
   logic [2:0]        dbg_saved_ccr;

   execute_memory_buffer #(.DATA_W(DATA_W), .OP_W(OP_W), .REG_W(REG_W)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .alu_op(alu_op), .alu_out(alu_out), .alu_flags(alu_flags),
      .flags_we(flags_we), .jump_taken(jump_taken), .store_data(store_data),
      .rdst(rdst), .reg_write(reg_write), .mem_read(mem_read),
      .mem_write(mem_write), .interrupt(interrupt), .ccr(ccr),
      .flush_upstream(flush_upstream), .int_ack(int_ack), .m_valid(m_valid),
      .m_alu_out(m_alu_out), .m_store_data(m_store_data), .m_rdst(m_rdst),
      .m_reg_write(m_reg_write), .m_mem_read(m_mem_read),
      .m_mem_write(m_mem_write), .dbg_state(dbg_state),
      .dbg_saved_ccr(dbg_saved_ccr)
   );

   // scoreboard
   logic [W-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   // reference model state
   logic         md_state;
   logic [2:0]   md_ccr, md_saved;
   logic         md_ack;
   logic [W-1:0] md_stage;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic idle_inputs();
      rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
      alu_op = '0; alu_out = '0; alu_flags = '0; flags_we = 1'b0;
      jump_taken = 1'b0; store_data = '0; rdst = '0;
      reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; interrupt = 1'b0;
   endtask

   task automatic instr(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] res,
                        input logic fwe, input logic [2:0] fl, input logic jt,
                        input logic [REG_W-1:0] rd);
      in_valid = 1'b1; alu_op = op; alu_out = res; flags_we = fwe;
      alu_flags = fl; jump_taken = jt; rdst = rd; reg_write = 1'b1;
      store_data = DATA_W'($urandom_range(0, 65535));
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   // One clock: predict, check combinational flush, clock, check registers.
   task automatic cycle();
      logic       acc, jcc;
      logic [2:0] cn;
      acc = in_valid & ~flush & ~stall & ~md_state;
      jcc = (alu_op == 5'd20) || (alu_op == 5'd21) || (alu_op == 5'd22);
      cn  = md_ccr;
      if (acc) begin
         if (alu_op == 5'd26) cn = md_saved;
         else if (flags_we) cn = alu_flags;
         else if (jump_taken && jcc) begin
            if (alu_op == 5'd20) cn[0] = 1'b0;
            else if (alu_op == 5'd21) cn[1] = 1'b0;
            else cn[2] = 1'b0;
         end
      end
      #1;
      chk("flush_upstream", 64'(flush_upstream), 64'(acc & jump_taken & jcc));
      if (rst) begin
         md_stage = '0; md_ccr = 3'b000; md_saved = 3'b000;
         md_state = 1'b0; md_ack = 1'b0;
      end else if (!stall) begin
         md_stage = acc ? {1'b1, alu_out, store_data, rdst, reg_write, mem_read, mem_write} : '0;
         if (!md_state) begin
            if (interrupt) begin
               md_saved = cn; md_state = 1'b1; md_ack = 1'b1;
            end else begin
               md_ack = 1'b0;
            end
         end else begin
            md_state = 1'b0; md_ack = 1'b0;
         end
         md_ccr = cn;
      end
      exp_q.push_back(md_stage);
      @(posedge clk);
      #1;
      chk("stage", 64'({m_valid, m_alu_out, m_store_data, m_rdst, m_reg_write, m_mem_read, m_mem_write}),
          64'(exp_q.pop_front()));
      chk("ccr", 64'(ccr), 64'(md_ccr));
      chk("saved_ccr", 64'(dbg_saved_ccr), 64'(md_saved));
      chk("state", 64'(dbg_state), 64'(md_state));
      chk("int_ack", 64'(int_ack), 64'(md_ack));
   endtask

   initial begin
      md_state = 1'b0; md_ccr = 3'b000; md_saved = 3'b000; md_ack = 1'b0; md_stage = '0;
      idle_inputs();

      // reset
      rst = 1'b1; in_valid = 1'b1; alu_out = 16'hffff;
      cycle();
      cycle();
      chk("reset_ccr", 64'(ccr), 64'(3'b000));
      chk("reset_m_valid", 64'(m_valid), 64'(1'b0));
      chk("reset_int_ack", 64'(int_ack), 64'(1'b0));
      idle_inputs();

      // ADD with flags
      instr(5'd1, 16'h1234, 1'b1, 3'b101, 1'b0, 3'd3);
      cycle();
      chk("add_m_valid", 64'(m_valid), 64'(1'b1));
      chk("add_m_alu_out", 64'(m_alu_out), 64'(16'h1234));
      chk("add_m_rdst", 64'(m_rdst), 64'(3'd3));
      chk("add_ccr", 64'(ccr), 64'(3'b101));

      // ccr = 001, then JZ taken
      instr(5'd2, 16'h0001, 1'b1, 3'b001, 1'b0, 3'd1);
      cycle();
      instr(5'd20, 16'h0040, 1'b0, 3'b000, 1'b1, 3'd0);
      reg_write = 1'b0;
      #1;
      chk("jz_flush_same_cycle", 64'(flush_upstream), 64'(1'b1));
      cycle();
      chk("jz_ccr_cleared", 64'(ccr), 64'(3'b000));
      chk("jz_passes_to_mem", 64'(m_valid), 64'(1'b1));

      // JN not taken
      instr(5'd2, 16'h0002, 1'b1, 3'b010, 1'b0, 3'd2);
      cycle();
      instr(5'd21, 16'h0050, 1'b0, 3'b000, 1'b0, 3'd0);
      cycle();
      chk("jn_not_taken_ccr", 64'(ccr), 64'(3'b010));

      // JC taken while stalled must not flush or clear
      instr(5'd22, 16'h0060, 1'b0, 3'b000, 1'b1, 3'd0);
      stall = 1'b1;
      cycle();
      chk("stall_jc_ccr", 64'(ccr), 64'(3'b010));

      // SUB held under stall for 3 cycles
      instr(5'd3, 16'habcd, 1'b1, 3'b110, 1'b0, 3'd5);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall_ccr_frozen", 64'(ccr), 64'(3'b010));
         chk("stall_m_alu_frozen", 64'(m_alu_out), 64'(16'h0050));
      end
      stall = 1'b0;
      cycle();
      chk("sub_after_stall_alu", 64'(m_alu_out), 64'(16'habcd));
      chk("sub_after_stall_ccr", 64'(ccr), 64'(3'b110));

      // interrupt with AND accepted in the same cycle
      instr(5'd4, 16'h0f0f, 1'b1, 3'b001, 1'b0, 3'd4);
      interrupt = 1'b1;
      cycle();
      chk("int_saved_ccr", 64'(dbg_saved_ccr), 64'(3'b001));
      chk("int_ack_high", 64'(int_ack), 64'(1'b1));
      chk("int_and_completes", 64'(m_valid), 64'(1'b1));
      interrupt = 1'b0;
      instr(5'd1, 16'h7777, 1'b1, 3'b111, 1'b0, 3'd6);
      cycle();
      chk("save_bubble", 64'(m_valid), 64'(1'b0));
      chk("save_ack_drops", 64'(int_ack), 64'(1'b0));
      chk("save_ccr_held", 64'(ccr), 64'(3'b001));
      instr(5'd7, 16'h0000, 1'b1, 3'b100, 1'b0, 3'd0);
      cycle();
      chk("setc_ccr", 64'(ccr), 64'(3'b100));
      instr(5'd26, 16'h0000, 1'b0, 3'b000, 1'b0, 3'd0);
      cycle();
      chk("rti_restore", 64'(ccr), 64'(3'b001));

      // stall while in SAVE keeps int_ack high
      idle_inputs();
      interrupt = 1'b1;
      cycle();
      interrupt = 1'b0; stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("save_stall_ack", 64'(int_ack), 64'(1'b1));
      end
      stall = 1'b0;
      cycle();
      chk("save_stall_exit", 64'(dbg_state), 64'(1'b0));

      // RTI together with interrupt: saved level is the restored ccr
      instr(5'd2, 16'h0003, 1'b1, 3'b010, 1'b0, 3'd1);
      cycle();
      instr(5'd26, 16'h0000, 1'b0, 3'b000, 1'b0, 3'd0);
      interrupt = 1'b1;
      cycle();
      chk("rti_int_ccr", 64'(ccr), 64'(3'b001));
      chk("rti_int_saved", 64'(dbg_saved_ccr), 64'(3'b001));
      idle_inputs();
      cycle();

      // reset while in SAVE
      instr(5'd2, 16'h0004, 1'b1, 3'b110, 1'b0, 3'd2);
      interrupt = 1'b1;
      cycle();
      interrupt = 1'b0; rst = 1'b1;
      cycle();
      chk("rst_save_state", 64'(dbg_state), 64'(1'b0));
      chk("rst_save_ack", 64'(int_ack), 64'(1'b0));
      chk("rst_save_ccr", 64'(ccr), 64'(3'b000));
      chk("rst_save_stage", 64'({m_valid, m_alu_out, m_store_data, m_rdst}), 64'(0));

      // flush beats in_valid
      idle_inputs();
      instr(5'd1, 16'hffff, 1'b1, 3'b111, 1'b0, 3'd7);
      flush = 1'b1;
      cycle();
      chk("flush_bubble_valid", 64'(m_valid), 64'(1'b0));
      chk("flush_ccr_held", 64'(ccr), 64'(3'b000));

      // randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         rst        = ($urandom_range(0, 99) == 0);
         stall      = ($urandom_range(0, 5) == 0);
         flush      = ($urandom_range(0, 7) == 0);
         in_valid   = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0: alu_op = 5'd20;
            1: alu_op = 5'd21;
            2: alu_op = 5'd22;
            3: alu_op = 5'd26;
            default: alu_op = OP_W'($urandom_range(0, 31));
         endcase
         alu_out    = DATA_W'($urandom_range(0, 65535));
         store_data = DATA_W'($urandom_range(0, 65535));
         alu_flags  = 3'($urandom_range(0, 7));
         flags_we   = ($urandom_range(0, 1) == 1);
         jump_taken = ($urandom_range(0, 1) == 1);
         rdst       = REG_W'($urandom_range(0, 7));
         reg_write  = ($urandom_range(0, 1) == 1);
         mem_read   = ($urandom_range(0, 1) == 1);
         mem_write  = ($urandom_range(0, 1) == 1);
         interrupt  = int_ack ? 1'b0 : ($urandom_range(0, 9) == 0);
         cycle();
      end

      // final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
